// File: rtl/amp_bcd_pkg.sv
// Shared defaults, FSM state type and iteration count for the amplitude-to-BCD converter.
package amp_bcd_pkg;

    localparam int unsigned DATA_W_DEF     = 9;
    localparam int unsigned BCD_DIGITS_DEF = 3;
    localparam int unsigned SHIFT_ITERS    = DATA_W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Double-dabble needs one step per binary input bit.
    function automatic int unsigned shift_iters(input int unsigned data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/amp_bcd_conv_dabble_step.sv
// bcd_dabble_step: one combinational double-dabble step (add 3 to digits >= 5, then shift left)
// on a {bcd, binary} scratch vector.
module bcd_dabble_step
    import amp_bcd_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned BCD_DIGITS = BCD_DIGITS_DEF
) (
    input  logic [DATA_W+4*BCD_DIGITS-1:0] scratch,
    output logic [DATA_W+4*BCD_DIGITS-1:0] next_c
);

    localparam int unsigned SW = DATA_W + 4 * BCD_DIGITS;

    logic [SW-1:0] adj;

    always_comb begin
        adj = scratch;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (adj[DATA_W+4*i +: 4] >= 4'd5) begin
                adj[DATA_W+4*i +: 4] = adj[DATA_W+4*i +: 4] + 4'd3;
            end
        end
        next_c = {adj[SW-2:0], 1'b0};
    end

endmodule

// File: rtl/amp_bcd_conv.sv
// Peak-to-peak amplitude (max - min, saturating at 0) converted to BCD by a serial double-dabble.
// Optional sticky overrun flag for ignored win_done pulses, enabled by AMP_BCD_OVR_EN.
module amp_bcd_conv
    import amp_bcd_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned BCD_DIGITS = BCD_DIGITS_DEF
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       max_in,
    input  logic [DATA_W-1:0]       min_in,
    input  logic                    win_done,
    output logic [DATA_W-1:0]       amp_out,
    output logic [4*BCD_DIGITS-1:0] bcd_out,
    output logic                    bcd_valid,
`ifdef AMP_BCD_OVR_EN
    output logic                    busy,
    output logic                    ovr_flag
`else
    output logic                    busy
`endif
);

    localparam int unsigned SW    = DATA_W + 4 * BCD_DIGITS;
    localparam int unsigned ITERS = shift_iters(DATA_W);
    localparam int unsigned CNT_W = $clog2(ITERS + 1);

    state_t            state, state_n;
    logic [DATA_W-1:0] max_r, min_r, amp_r;
    logic [SW-1:0]     scratch, step_c;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W:0]   diff_c;
    logic [DATA_W-1:0] amp_c;

    // Extra bit catches the borrow when min exceeds max.
    assign diff_c = {1'b0, max_r} - {1'b0, min_r};
    assign amp_c  = diff_c[DATA_W] ? '0 : diff_c[DATA_W-1:0];

    bcd_dabble_step #(
        .DATA_W     (DATA_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_step (
        .scratch (scratch),
        .next_c  (step_c)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (win_done) state_n = CALC;
            CALC:    state_n = SHIFT;
            SHIFT:   if (cnt == CNT_W'(ITERS - 1)) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: operand capture, subtraction, serial conversion and output registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            max_r     <= '0;
            min_r     <= '0;
            amp_r     <= '0;
            scratch   <= '0;
            cnt       <= '0;
            amp_out   <= '0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_done) begin
                        max_r <= max_in;
                        min_r <= min_in;
                    end
                end
                CALC: begin
                    amp_r   <= amp_c;
                    scratch <= SW'(amp_c);
                    cnt     <= '0;
                end
                SHIFT: begin
                    scratch <= step_c;
                    cnt     <= cnt + CNT_W'(1);
                end
                DONE: begin
                    amp_out <= amp_r;
                    bcd_out <= scratch[SW-1:DATA_W];
                end
                default: ;
            endcase
            bcd_valid <= (state == DONE);
            busy      <= (state_n != IDLE);
        end
    end

`ifdef AMP_BCD_OVR_EN
    // Sticky until reset: a window ended while a conversion was still running.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            ovr_flag <= 1'b0;
        end else if (win_done && (state != IDLE)) begin
            ovr_flag <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_amp_bcd_conv.sv
// Self-checking bench for amp_bcd_conv: directed scenarios plus randomized conversions
// against an arithmetic reference model. Define AMP_BCD_OVR_EN to also check ovr_flag.
module tb_amp_bcd_conv;

    localparam int unsigned DATA_W     = 9;
    localparam int unsigned BCD_DIGITS = 3;
    localparam int unsigned LAT        = DATA_W + 2;

    logic                    clock;
    logic                    rst;
    logic [DATA_W-1:0]       max_in;
    logic [DATA_W-1:0]       min_in;
    logic                    win_done;
    logic [DATA_W-1:0]       amp_out;
    logic [4*BCD_DIGITS-1:0] bcd_out;
    logic                    bcd_valid;
    logic                    busy;
`ifdef AMP_BCD_OVR_EN
    logic                    ovr_flag;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    amp_bcd_conv #(
        .DATA_W     (DATA_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .max_in    (max_in),
        .min_in    (min_in),
        .win_done  (win_done),
        .amp_out   (amp_out),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid),
`ifdef AMP_BCD_OVR_EN
        .busy      (busy),
        .ovr_flag  (ovr_flag)
`else
        .busy      (busy)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_amp(input int mx, input int mn);
        return (mx >= mn) ? (mx - mn) : 0;
    endfunction

    function automatic logic [11:0] ref_bcd(input int v);
        logic [11:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Start a conversion now; returns in the cycle where the result is visible.
    // Operands are scrambled after capture; overlap injects an extra win_done mid-run.
    task automatic conv(input int mx, input int mn, input bit overlap);
        int ea;
        ea = ref_amp(mx, mn);
        max_in   = DATA_W'(mx);
        min_in   = DATA_W'(mn);
        win_done = 1'b1;
        step();
        win_done = 1'b0;
        check("busy_after_capture", 32'(busy), 32'd1);
        for (int k = 1; k <= int'(LAT); k++) begin
            if (k == 1) begin
                max_in = DATA_W'($urandom_range(0, 511));
                min_in = DATA_W'($urandom_range(0, 511));
            end
            if (overlap && k == 5) win_done = 1'b1;
            if (overlap && k == 6) win_done = 1'b0;
            step();
            if (k < int'(LAT)) begin
                check("busy_during", 32'(busy), 32'd1);
                check("valid_early", 32'(bcd_valid), 32'd0);
            end
        end
        check("valid_pulse", 32'(bcd_valid), 32'd1);
        check("amp_out", 32'(amp_out), 32'(ea));
        check("bcd_out", 32'(bcd_out), 32'(ref_bcd(ea)));
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic hold_check(input int mx, input int mn);
        int ea;
        ea = ref_amp(mx, mn);
        step();
        check("valid_one_cycle", 32'(bcd_valid), 32'd0);
        check("amp_hold", 32'(amp_out), 32'(ea));
        check("bcd_hold", 32'(bcd_out), 32'(ref_bcd(ea)));
    endtask

    initial begin
        int mx, mn;
        bit seen_valid;
        rst      = 1'b1;
        win_done = 1'b0;
        max_in   = '0;
        min_in   = '0;
        repeat (3) step();
        check("rst_amp", 32'(amp_out), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check("rst_valid", 32'(bcd_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef AMP_BCD_OVR_EN
        check("rst_ovr", 32'(ovr_flag), 32'd0);
`endif
        rst = 1'b0;
        step();

        conv(300, 45, 1'b0);
        check("dir_300_45", 32'(bcd_out), 32'h255);
        hold_check(300, 45);
        conv(10, 20, 1'b0);
        check("dir_saturate", 32'(amp_out), 32'd0);
        hold_check(10, 20);
        conv(511, 0, 1'b0);
        check("dir_511", 32'(bcd_out), 32'h511);
        hold_check(511, 0);
        conv(0, 0, 1'b0);
        hold_check(0, 0);

`ifdef AMP_BCD_OVR_EN
        check("ovr_clear_before", 32'(ovr_flag), 32'd0);
`endif
        conv(200, 50, 1'b1);
`ifdef AMP_BCD_OVR_EN
        check("ovr_set", 32'(ovr_flag), 32'd1);
`endif
        hold_check(200, 50);
        step();
        check("idle_after_overlap", 32'(busy), 32'd0);

        // Abort in the middle of SHIFT.
        max_in   = DATA_W'(123);
        min_in   = DATA_W'(0);
        win_done = 1'b1;
        step();
        win_done = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        #1;
        check("abort_amp", 32'(amp_out), 32'd0);
        check("abort_bcd", 32'(bcd_out), 32'd0);
        check("abort_valid", 32'(bcd_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
`ifdef AMP_BCD_OVR_EN
        check("abort_ovr", 32'(ovr_flag), 32'd0);
`endif
        step();
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (bcd_valid || busy) seen_valid = 1'b1;
        end
        check("no_valid_after_abort", 32'(seen_valid), 32'd0);
        conv(99, 0, 1'b0);
        check("dir_99", 32'(bcd_out), 32'h099);
        hold_check(99, 0);

        // Back-to-back: next win_done lands on the bcd_valid cycle.
        conv(400, 1, 1'b0);
        conv(123, 100, 1'b0);
        hold_check(123, 100);

        for (int n = 0; n < 24; n++) begin
            mx = int'($urandom_range(0, 511));
            mn = ($urandom_range(0, 3) == 0) ? mx : int'($urandom_range(0, 511));
            conv(mx, mn, 1'b0);
            if ($urandom_range(0, 2) != 0) begin
                hold_check(mx, mn);
                repeat ($urandom_range(0, 2)) step();
            end
        end

`ifdef AMP_BCD_OVR_EN
        check("ovr_stays_clear", 32'(ovr_flag), 32'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
